// File: rtl/and4_run_detector_pkg.sv
// and4_run_detector_pkg: shared FSM state encoding and parameter defaults.
package and4_run_detector_pkg;

    localparam int RUN_LEN_DEF = 3;
    localparam int CNT_W_DEF   = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        RUN    = 2'b01,
        DETECT = 2'b10
    } state_t;

endpackage

// File: rtl/and4_run_detector_and4.sv
// and4_run_detector_and4: combinational 4-input AND.
module and4_run_detector_and4 (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic y
);

    assign y = a & b & c & d;

endmodule

// File: rtl/and4_run_detector.sv
// and4_run_detector: counts consecutive all-ones AND4 samples and flags a run of RUN_LEN.
module and4_run_detector
    import and4_run_detector_pkg::*;
#(
    parameter int RUN_LEN = RUN_LEN_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             A,
    input  logic             B,
    input  logic             C,
    input  logic             D,
    output logic             and_q,
    output logic [CNT_W-1:0] run_cnt,
    output logic             hit,
    output logic             hit_p
);

    localparam logic [CNT_W-1:0] LIM = CNT_W'(RUN_LEN);

    logic             all_ones;
    logic [CNT_W-1:0] cnt_n;
    state_t           state, state_n;

    and4_run_detector_and4 u_and4 (
        .a(A),
        .b(B),
        .c(C),
        .d(D),
        .y(all_ones)
    );

    always_comb begin
        cnt_n   = run_cnt;
        state_n = state;
        if (clr) begin
            cnt_n   = '0;
            state_n = IDLE;
        end else if (en) begin
            cnt_n   = !all_ones ? '0 : (run_cnt >= LIM ? LIM : run_cnt + 1'b1);
            state_n = !all_ones ? IDLE : (cnt_n == LIM ? DETECT : RUN);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // hit_p fires only on the transition into DETECT, never while staying there
    always_ff @(posedge clk) begin
        if (rst) begin
            and_q   <= 1'b0;
            run_cnt <= '0;
            hit     <= 1'b0;
            hit_p   <= 1'b0;
        end else begin
            if (en) and_q <= all_ones;
            run_cnt <= cnt_n;
            hit     <= state_n == DETECT;
            hit_p   <= state_n == DETECT && state != DETECT;
        end
    end

endmodule

// File: tb/tb_and4_run_detector.sv
// tb_and4_run_detector: directed and random checks against a behavioural run-length model.
module tb_and4_run_detector;

    localparam int L = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1, en = 1'b0, clr = 1'b0;
    logic       A = 1'b0, B = 1'b0, C = 1'b0, D = 1'b0;
    logic       and_q, hit, hit_p;
    logic [3:0] run_cnt;

    int total = 0, bad = 0;
    int m_and = 0, m_cnt = 0, m_hit = 0, m_hitp = 0;

    always #5 clk = ~clk;

    and4_run_detector #(.RUN_LEN(L), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr),
        .A(A), .B(B), .C(C), .D(D),
        .and_q(and_q), .run_cnt(run_cnt), .hit(hit), .hit_p(hit_p)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic e, input logic c, input logic r, input logic [3:0] v);
        int was_hit;
        en = e; clr = c; rst = r;
        {A, B, C, D} = v;
        @(posedge clk);
        if (r) begin
            m_and = 0; m_cnt = 0; m_hit = 0; m_hitp = 0;
        end else begin
            if (e) m_and = (v == 4'hF) ? 1 : 0;
            if (c) begin
                m_cnt = 0; m_hit = 0; m_hitp = 0;
            end else if (e) begin
                was_hit = m_hit;
                m_cnt = (v == 4'hF) ? ((m_cnt + 1 > L) ? L : m_cnt + 1) : 0;
                m_hit = (m_cnt == L) ? 1 : 0;
                m_hitp = (m_hit == 1 && was_hit == 0) ? 1 : 0;
            end else m_hitp = 0;
        end
        #1;
        chk("and_q", int'(and_q), m_and);
        chk("run_cnt", int'(run_cnt), m_cnt);
        chk("hit", int'(hit), m_hit);
        chk("hit_p", int'(hit_p), m_hitp);
    endtask

    initial begin
        step(0, 0, 1, 4'h0);
        step(1, 0, 0, 4'h0);
        chk("rst0_cnt", int'(run_cnt), 0);
        step(1, 0, 0, 4'hF); chk("r1", int'(run_cnt), 1);
        step(1, 0, 0, 4'hF); chk("r2", int'(run_cnt), 2);
        step(1, 0, 0, 4'hF); chk("r3", int'(run_cnt), 3); chk("r3_hitp", int'(hit_p), 1);
        step(1, 0, 0, 4'hF); chk("det_hold", int'(run_cnt), 3); chk("det_nopulse", int'(hit_p), 0);
        chk("det_hit", int'(hit), 1);
        step(1, 0, 0, 4'h7); chk("det_exit", int'(hit), 0); chk("det_exit_cnt", int'(run_cnt), 0);
        step(1, 0, 0, 4'hF);
        step(1, 0, 0, 4'hF);
        step(1, 0, 0, 4'hB); chk("break_cnt", int'(run_cnt), 0); chk("break_hit", int'(hit), 0);
        step(1, 0, 0, 4'hF);
        step(0, 0, 0, 4'h0); chk("gap1", int'(run_cnt), 1);
        step(0, 0, 0, 4'h0); chk("gap2", int'(run_cnt), 1);
        step(1, 0, 0, 4'hF); chk("gap_hitp0", int'(hit_p), 0);
        step(1, 0, 0, 4'hF); chk("gap_hitp", int'(hit_p), 1);
        step(1, 0, 0, 4'h0);
        step(1, 0, 0, 4'hF);
        step(1, 0, 0, 4'hF);
        step(1, 1, 0, 4'hF); chk("clr_cnt", int'(run_cnt), 0); chk("clr_andq", int'(and_q), 1);
        chk("clr_hit", int'(hit), 0);
        step(1, 0, 0, 4'hF);
        step(1, 0, 0, 4'hF);
        step(1, 0, 0, 4'hF);
        step(1, 1, 1, 4'hF); chk("rst_andq", int'(and_q), 0); chk("rst_hit", int'(hit), 0);
        step(1, 0, 0, 4'hF); chk("rst_first", int'(run_cnt), 1);
        for (int i = 0; i < 400; i++) begin
            logic [3:0] v;
            v = ($urandom_range(0, 3) != 0) ? 4'hF : 4'($urandom);
            step(1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 19) == 0),
                 1'($urandom_range(0, 39) == 0), v);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
